// File: rtl/fir_ctrl_pkg.sv
// Shared types and constants for the multi-channel FIR sequencer.
// Optional build macro used by the top: FIR_CTRL_OVERRUN_EN.
package fir_ctrl_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_INIT = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_EXEC = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    // Coefficient ROM read latency, spent in the WAIT state.
    localparam int WAIT_LAT = 1;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_INIT = ST_INIT,
        S_WAIT = ST_WAIT,
        S_EXEC = ST_EXEC,
        S_DONE = ST_DONE
    } fir_state_t;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fir_tap_counter.sv
// Loadable up-counter that saturates at a programmable terminal value.
// Used for both the tap index and the channel index.
module fir_tap_counter #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         inc_i,
    input  logic [W-1:0] term_val_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i && !tc_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == term_val_i);

endmodule

// File: rtl/fir_mc_seq_ctrl.sv
// Multi-channel FIR sequencer: one TDM frame per handshake, runtime tap count.
// Build macro FIR_CTRL_OVERRUN_EN adds a sticky overrun flag output.
module fir_mc_seq_ctrl
    import fir_ctrl_pkg::*;
#(
    parameter int  FIR_SIZE = 64,
    parameter int  NUM_CH   = 4,
    localparam int AW       = $clog2(FIR_SIZE),
    localparam int CW       = ch_width(NUM_CH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inputValid,
    output logic          inputReady,
    input  logic [AW:0]   tapCount,
    output logic          outputValid,
    input  logic          outputReady,
    output logic [AW-1:0] address,
    output logic [CW-1:0] channel,
    output logic          flush,
    output logic          shift,
    output logic          freeze,
    output logic          macEn,
`ifdef FIR_CTRL_OVERRUN_EN
    output logic          overrun,
`endif
    output logic          frameDone
);

    fir_state_t    ps_q, ps_d;
    logic [AW:0]   n_q, n_d;
    logic [3:0]    wait_q, wait_d;

    logic [AW-1:0] tap_cnt, tap_term;
    logic          tap_tc, tap_load, tap_inc;
    logic [CW-1:0] ch_cnt;
    logic          ch_tc, ch_load, ch_inc;
    logic          done_hs;

    assign done_hs  = (ps_q == S_DONE) && outputReady;
    assign tap_term = AW'(n_q - 1'b1);

    // Tap index sits at 0 outside EXEC/DONE, so WAIT presents address 0 and
    // every EXEC starts from 0; DONE keeps the last tap until the handshake.
    assign tap_load = ((ps_q != S_EXEC) && (ps_q != S_DONE)) || done_hs;
    assign tap_inc  = (ps_q == S_EXEC);

    assign ch_load  = done_hs && ch_tc;
    assign ch_inc   = done_hs;

    fir_tap_counter #(.W(AW)) u_tap_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tap_load),
        .load_val_i ('0),
        .inc_i      (tap_inc),
        .term_val_i (tap_term),
        .cnt_o      (tap_cnt),
        .tc_o       (tap_tc)
    );

    fir_tap_counter #(.W(CW)) u_ch_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (ch_load),
        .load_val_i ('0),
        .inc_i      (ch_inc),
        .term_val_i (CW'(NUM_CH - 1)),
        .cnt_o      (ch_cnt),
        .tc_o       (ch_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps_q   <= S_IDLE;
            n_q    <= '0;
            wait_q <= '0;
        end else begin
            ps_q   <= ps_d;
            n_q    <= n_d;
            wait_q <= wait_d;
        end
    end

    always_comb begin
        ps_d        = ps_q;
        n_d         = n_q;
        wait_d      = 4'd0;
        inputReady  = 1'b0;
        outputValid = 1'b0;
        flush       = 1'b0;
        shift       = 1'b0;
        freeze      = 1'b0;
        macEn       = 1'b0;
        frameDone   = 1'b0;
        unique case (ps_q)
            S_IDLE: begin
                inputReady = ~rst;
                if (inputValid) begin
                    ps_d = S_INIT;
                    n_d  = (tapCount == '0 || tapCount > (AW+1)'(FIR_SIZE))
                         ? (AW+1)'(FIR_SIZE) : tapCount;
                end
            end
            S_INIT: begin
                shift = 1'b1;
                flush = 1'b1;
                ps_d  = S_WAIT;
            end
            S_WAIT: begin
                wait_d = wait_q + 4'd1;
                if (wait_q == 4'(WAIT_LAT - 1)) begin
                    ps_d = S_EXEC;
                end
            end
            S_EXEC: begin
                macEn = 1'b1;
                if (tap_tc) begin
                    ps_d = S_DONE;
                end
            end
            S_DONE: begin
                outputValid = 1'b1;
                freeze      = 1'b1;
                // Decoded from state/counter only: marks the last channel's
                // result, consumed in the same cycle when outputReady is high.
                frameDone   = ch_tc;
                if (outputReady) begin
                    ps_d = ch_tc ? S_IDLE : S_INIT;
                end
            end
            default: ps_d = S_IDLE;
        endcase
    end

    assign address = tap_cnt;
    assign channel = ch_cnt;

`ifdef FIR_CTRL_OVERRUN_EN
    logic busy_vld, busy_vld_q, overrun_q;

    assign busy_vld = inputValid && (ps_q != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_vld_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            busy_vld_q <= busy_vld;
            overrun_q  <= overrun_q | (busy_vld & busy_vld_q);
        end
    end

    assign overrun = overrun_q;
`endif

endmodule

// File: tb/tb_fir_mc_seq_ctrl.sv
// Bench for fir_mc_seq_ctrl: NUM_CH=1 and NUM_CH=4 instances share stimulus,
// a per-channel timing model checks every cycle, directed points pin it.
module tb_fir_mc_seq_ctrl;

    localparam int FS = 64;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          inputValid = 1'b0;
    logic          outputReady = 1'b1;
    logic [AW:0]   tapCount = 7'd8;

    logic [1:0]    ir, ov, fl, sh, fz, me, fd;
    logic [AW-1:0] ad1, ad4;
    logic [0:0]    ch1;
    logic [1:0]    ch4;
`ifdef FIR_CTRL_OVERRUN_EN
    logic [1:0]    ovr;
`endif

    int checks = 0;
    int errs   = 0;
    int rel    = 0;

    always #5 clk = ~clk;

    fir_mc_seq_ctrl #(.FIR_SIZE(FS), .NUM_CH(1)) dut1 (
        .clk(clk), .rst(rst), .inputValid(inputValid), .inputReady(ir[0]),
        .tapCount(tapCount), .outputValid(ov[0]), .outputReady(outputReady),
        .address(ad1), .channel(ch1), .flush(fl[0]), .shift(sh[0]),
        .freeze(fz[0]), .macEn(me[0]),
`ifdef FIR_CTRL_OVERRUN_EN
        .overrun(ovr[0]),
`endif
        .frameDone(fd[0])
    );

    fir_mc_seq_ctrl #(.FIR_SIZE(FS), .NUM_CH(4)) dut4 (
        .clk(clk), .rst(rst), .inputValid(inputValid), .inputReady(ir[1]),
        .tapCount(tapCount), .outputValid(ov[1]), .outputReady(outputReady),
        .address(ad4), .channel(ch4), .flush(fl[1]), .shift(sh[1]),
        .freeze(fz[1]), .macEn(me[1]),
`ifdef FIR_CTRL_OVERRUN_EN
        .overrun(ovr[1]),
`endif
        .frameDone(fd[1])
    );

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, a, e, $time);
        end
    endtask

    // Model: per-instance offset within the current channel's slot.
    // off 0 = flush/shift, 1 = ROM wait, 2..N+1 = taps, >=N+2 = result held.
    int nch[2]   = '{1, 4};
    bit m_act[2] = '{0, 0};
    int m_n[2]   = '{0, 0};
    int m_ch[2]  = '{0, 0};
    int m_off[2] = '{0, 0};

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_act[i] <= 1'b0;
                m_ch[i]  <= 0;
                m_off[i] <= 0;
            end else if (!m_act[i]) begin
                if (inputValid) begin
                    m_act[i] <= 1'b1;
                    m_n[i]   <= (tapCount == 0 || tapCount > FS) ? FS : int'(tapCount);
                    m_ch[i]  <= 0;
                    m_off[i] <= 0;
                end
            end else if (m_off[i] < m_n[i] + 2) begin
                m_off[i] <= m_off[i] + 1;
            end else if (outputReady) begin
                if (m_ch[i] == nch[i] - 1) begin
                    m_act[i] <= 1'b0;
                end else begin
                    m_ch[i]  <= m_ch[i] + 1;
                    m_off[i] <= 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            bit e_mac, e_res;
            int e_ad, a_ad, a_ch;
            e_mac = m_act[i] && m_off[i] >= 2 && m_off[i] <= m_n[i] + 1;
            e_res = m_act[i] && m_off[i] >= m_n[i] + 2;
            e_ad  = e_mac ? m_off[i] - 2 : (e_res ? m_n[i] - 1 : 0);
            a_ad  = (i == 0) ? int'(ad1) : int'(ad4);
            a_ch  = (i == 0) ? int'(ch1) : int'(ch4);
            chk("m_inputReady", ir[i], !m_act[i] && !rst);
            chk("m_shift",      sh[i], m_act[i] && m_off[i] == 0);
            chk("m_flush",      fl[i], m_act[i] && m_off[i] == 0);
            chk("m_macEn",      me[i], e_mac);
            chk("m_outputValid", ov[i], e_res);
            chk("m_freeze",     fz[i], e_res);
            chk("m_frameDone",  fd[i], e_res && m_ch[i] == nch[i] - 1);
            chk("m_address",    a_ad, e_ad);
            chk("m_channel",    a_ch, m_act[i] ? m_ch[i] : 0);
        end
    end

    task automatic wait_idle();
        int k = 0;
        @(negedge clk);
        while (ir != 2'b11 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk("idle_timeout", ir, 2'b11);
    endtask

    // Accept at the next edge (spec edge 0); rel then counts cycles 1,2,...
    task automatic start(input int tap);
        @(posedge clk);
        #1 tapCount = 7'(tap);
        inputValid = 1'b1;
        @(posedge clk);
        #1 inputValid = 1'b0;
        rel = 0;
    endtask

    task automatic to_cycle(input int k);
        while (rel < k) begin
            @(negedge clk);
            rel++;
        end
    endtask

    initial begin
        int pulses;
        repeat (2) @(negedge clk);
        chk("rst_inputReady", ir, 2'b00);
        chk("rst_address", ad4, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        wait_idle();

        // 64 taps, single channel: taps on cycles 3..66, result on 67.
        start(64);
        to_cycle(3);  chk("t1_mac3", me[0], 1); chk("t1_addr3", ad1, 0);
        to_cycle(66); chk("t1_addr66", ad1, 63); chk("t1_ov66", ov[0], 0);
        to_cycle(67); chk("t1_ov67", ov[0], 1); chk("t1_fd67", fd[0], 1);
        to_cycle(68); chk("t1_ir68", ir[0], 1); chk("t1_ov68", ov[0], 0);
        wait_idle();

        // 8 taps, four channels of 11 cycles each.
        start(8);
        pulses = 0;
        for (int k = 1; k <= 45; k++) begin
            to_cycle(k);
            pulses += int'(ov[1]);
            if (k == 11) chk("t2_ch0_done", ch4, 0);
            if (k == 12) chk("t2_ch1_init", ch4, 1);
            if (k == 44) chk("t2_fd44", fd[1], 1);
            if (k == 45) chk("t2_ir45", ir[1], 1);
        end
        chk("t2_pulses", pulses, 4);
        wait_idle();

        // Out-of-range tap counts clamp to 64; a single tap still works.
        start(0);
        to_cycle(66); chk("t3a_mac66", me[1], 1); chk("t3a_addr66", ad4, 63);
        to_cycle(67); chk("t3a_ov67", ov[1], 1);
        wait_idle();
        start(100);
        to_cycle(66); chk("t3b_mac66", me[1], 1);
        to_cycle(67); chk("t3b_mac67", me[1], 0); chk("t3b_ov67", ov[1], 1);
        wait_idle();
        start(1);
        to_cycle(3); chk("t3c_mac3", me[1], 1); chk("t3c_addr3", ad4, 0);
        to_cycle(4); chk("t3c_mac4", me[1], 0); chk("t3c_ov4", ov[1], 1);
        wait_idle();

        // Backpressure: result of channel 0 held while outputReady is low.
        outputReady = 1'b0;
        start(2);
        to_cycle(10);
        chk("t4_ov_held", ov[1], 1); chk("t4_fz_held", fz[1], 1);
        chk("t4_addr_held", ad4, 1); chk("t4_ch_held", ch4, 0);
        #1 outputReady = 1'b1;
        to_cycle(11); chk("t4_ch_adv", ch4, 1); chk("t4_shift", sh[1], 1);
        wait_idle();

        // Asynchronous reset in the middle of channel 2's taps.
        start(8);
        to_cycle(27); chk("t5_pre_ch", ch4, 2); chk("t5_pre_mac", me[1], 1);
        #1 rst = 1'b1;
        #1 chk("t5_rst_mac", me[1], 0); chk("t5_rst_ch", ch4, 0);
        chk("t5_rst_addr", ad4, 0); chk("t5_rst_ir", ir[1], 0);
        @(posedge clk);
        #1 rst = 1'b0;
        start(8);
        to_cycle(1); chk("t5_new_ch", ch4, 0); chk("t5_new_shift", sh[1], 1);
        wait_idle();

`ifdef FIR_CTRL_OVERRUN_EN
        chk("t6_ovr_clear", ovr, 2'b00);
        @(posedge clk);
        #1 tapCount = 7'd4;
        inputValid = 1'b1;
        repeat (30) @(posedge clk);
        #1 chk("t6_ovr_set", ovr, 2'b11);
        inputValid = 1'b0;
        wait_idle();
        chk("t6_ovr_sticky", ovr, 2'b11);
        #1 rst = 1'b1;
        #1 chk("t6_ovr_rst", ovr, 2'b00);
        @(posedge clk);
        #1 rst = 1'b0;
        wait_idle();
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
